// File: rtl/nv_nvdla_sdp_relu_ctrl_pkg.sv
// Shared constants for the SDP ReLU sequencer: FSM encoding and skid depth.
package nv_nvdla_sdp_relu_ctrl_pkg;

  typedef logic [1:0] relu_state_t;

  localparam relu_state_t ST_IDLE  = 2'd0;
  localparam relu_state_t ST_RUN   = 2'd1;
  localparam relu_state_t ST_DRAIN = 2'd2;
  localparam relu_state_t ST_DONE  = 2'd3;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/nv_nvdla_sdp_relu_ctrl_if.sv
// Element stream bundle between BN output (in_*) and LUT/convertor input (out_*).
interface nv_nvdla_sdp_relu_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_pvld;
  logic                  in_prdy;
  logic [DATA_WIDTH-1:0] in_pd;
  logic                  out_pvld;
  logic                  out_prdy;
  logic [DATA_WIDTH-1:0] out_pd;

  modport master (
    output in_pvld, in_pd, out_prdy,
    input  in_prdy, out_pvld, out_pd
  );

  modport slave (
    input  in_pvld, in_pd, out_prdy,
    output in_prdy, out_pvld, out_pd
  );
endinterface

// File: rtl/nv_nvdla_sdp_relu_skid.sv
// Two-entry valid/ready buffer; in-side ready is a flop so out_rdy_i never reaches it combinationally.
module nv_nvdla_sdp_relu_skid
  import nv_nvdla_sdp_relu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rdy_q, rdy_d;
  logic                  push, pop;

  assign push       = in_vld_i && rdy_q;
  assign pop        = (occ_q != 2'd0) && out_rdy_i;
  assign in_rdy_o   = rdy_q;
  assign out_vld_o  = (occ_q != 2'd0);
  assign out_data_o = ent0_q;
  assign occ_o      = occ_q;

  // ent0 is always the head; ent1 only holds data while two entries are queued.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = in_data_i;
        else               ent1_d = in_data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = in_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_data_i;
        end
      end
      default: ;
    endcase
    rdy_d = (occ_d < 2'(SKID_DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_relu_ctrl.sv
// Per-layer SDP ReLU sequencer: FSM, element/negative counters, ReLU datapath, skid output.
// Optional ReLU-N clipping is enabled by defining NV_NVDLA_SDP_RELU_CLIP_EN.
module nv_nvdla_sdp_relu_ctrl
  import nv_nvdla_sdp_relu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  op_en,
  input  logic                  cfg_relu_bypass,
  input  logic [CNT_WIDTH-1:0]  cfg_elem_cnt,
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
  input  logic [DATA_WIDTH-1:0] cfg_relu_clip,
  output logic [CNT_WIDTH-1:0]  clip_cnt,
`endif
  nv_nvdla_sdp_relu_ctrl_if.slave io,
  output logic                  busy,
  output logic                  layer_done,
  output logic [CNT_WIDTH-1:0]  neg_cnt
);

  relu_state_t           state_q, state_d;
  logic                  bypass_q, bypass_d;
  logic [CNT_WIDTH-1:0]  last_q, last_d;
  logic [CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]  neg_cnt_q, neg_cnt_d;
  logic                  start, accept, pop;
  logic                  skid_rdy;
  logic [1:0]            skid_occ;
  logic [DATA_WIDTH-1:0] res;
  logic                  neg_hit;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
  logic [DATA_WIDTH-1:0] clip_q, clip_d;
  logic [CNT_WIDTH-1:0]  clip_cnt_q, clip_cnt_d;
  logic                  clip_hit;
`endif

  assign start      = (state_q == ST_IDLE) && op_en;
  assign io.in_prdy = (state_q == ST_RUN) && skid_rdy;
  assign accept     = io.in_pvld && io.in_prdy;
  assign pop        = io.out_pvld && io.out_prdy;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign layer_done = (state_q == ST_DONE);
  assign neg_cnt    = neg_cnt_q;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
  assign clip_cnt   = clip_cnt_q;
`endif

  always_comb begin
    res     = io.in_pd;
    neg_hit = 1'b0;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
    clip_hit = 1'b0;
`endif
    if (!bypass_q) begin
      if (io.in_pd[DATA_WIDTH-1]) begin
        res     = '0;
        neg_hit = 1'b1;
      end
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
      else if ($signed(io.in_pd) > $signed(clip_q)) begin
        res      = clip_q;
        clip_hit = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bypass_d  = bypass_q;
    last_d    = last_q;
    in_cnt_d  = in_cnt_q;
    neg_cnt_d = neg_cnt_q;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
    clip_d     = clip_q;
    clip_cnt_d = clip_cnt_q;
`endif
    case (state_q)
      ST_IDLE:  if (op_en) state_d = ST_RUN;
      // compare before increment so an all-ones count never wraps in_cnt
      ST_RUN:   if (accept && (in_cnt_q == last_q)) state_d = ST_DRAIN;
      ST_DRAIN: if ((skid_occ == 2'd0) || ((skid_occ == 2'd1) && pop)) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    if (start) begin
      bypass_d  = cfg_relu_bypass;
      last_d    = cfg_elem_cnt;
      in_cnt_d  = '0;
      neg_cnt_d = '0;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
      clip_d     = cfg_relu_clip;
      clip_cnt_d = '0;
`endif
    end else if (accept) begin
      if (in_cnt_q != last_q)         in_cnt_d  = in_cnt_q + 1'b1;
      if (neg_hit && (neg_cnt_q != '1)) neg_cnt_d = neg_cnt_q + 1'b1;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
      if (clip_hit && (clip_cnt_q != '1)) clip_cnt_d = clip_cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q   <= ST_IDLE;
      bypass_q  <= 1'b0;
      last_q    <= '0;
      in_cnt_q  <= '0;
      neg_cnt_q <= '0;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
      clip_q     <= '0;
      clip_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bypass_q  <= bypass_d;
      last_q    <= last_d;
      in_cnt_q  <= in_cnt_d;
      neg_cnt_q <= neg_cnt_d;
`ifdef NV_NVDLA_SDP_RELU_CLIP_EN
      clip_q     <= clip_d;
      clip_cnt_q <= clip_cnt_d;
`endif
    end
  end

  nv_nvdla_sdp_relu_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i      (nvdla_core_clk),
    .rst_i      (nvdla_core_rst),
    .in_vld_i   (accept),
    .in_rdy_o   (skid_rdy),
    .in_data_i  (res),
    .out_vld_o  (io.out_pvld),
    .out_rdy_i  (io.out_prdy),
    .out_data_o (io.out_pd),
    .occ_o      (skid_occ)
  );

endmodule
